// File: rtl/spectrogram_frame_receiver.sv
// Deserialises the extractor's SL-framed PISO readout into indexed 12-bit words behind a small FIFO.
// Optional index-sequence checking is enabled with `define SPECTRO_RX_SEQ_CHECK_EN.
module spectrogram_frame_receiver #(
    parameter int WORD_W     = 12,
    parameter int IDX_W      = 4,
    parameter int NUM_WORDS  = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            serial_in,
    input  logic                            sl_in,
    input  logic [IDX_W-1:0]                sel_in,
    input  logic                            clr_err,
    output logic [WORD_W-1:0]               out_data,
    output logic [IDX_W-1:0]                out_index,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic                            frame_done,
    output logic                            err_short,
    output logic                            overrun,
    output logic                            seq_err,
    output logic [$clog2(FIFO_DEPTH):0]     fifo_count
);

    localparam int BIT_W = $clog2(WORD_W);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(WORD_W - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t             state;
    logic [BIT_W-1:0]   bitcnt;
    logic [WORD_W-1:0]  shreg;
    logic [IDX_W-1:0]   idx_reg;
    logic               push_req;

    logic [WORD_W-1:0]  mem_data [FIFO_DEPTH];
    logic [IDX_W-1:0]   mem_idx  [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   count;
    logic               full;
    logic               pop;
    logic               push_ok;

    // A load seen while still shifting truncates the current word and restarts on the new index.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            bitcnt    <= '0;
            shreg     <= '0;
            idx_reg   <= '0;
            push_req  <= 1'b0;
            err_short <= 1'b0;
        end else begin
            push_req  <= 1'b0;
            err_short <= 1'b0;
            case (state)
                IDLE: begin
                    if (sl_in) begin
                        idx_reg <= sel_in;
                        bitcnt  <= '0;
                        state   <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (sl_in) begin
                        err_short <= 1'b1;
                        idx_reg   <= sel_in;
                        bitcnt    <= '0;
                    end else begin
                        shreg <= {shreg[WORD_W-2:0], serial_in};
                        if (bitcnt == LAST_BIT) begin
                            push_req <= 1'b1;
                            bitcnt   <= '0;
                            state    <= IDLE;
                        end else begin
                            bitcnt <= bitcnt + BIT_W'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign out_valid  = (count != '0);
    assign full       = (count == CNT_W'(FIFO_DEPTH));
    assign pop        = out_valid && out_ready;
    assign push_ok    = push_req && (!full || pop);
    assign fifo_count = count;
    assign out_data   = out_valid ? mem_data[rd_ptr] : '0;
    assign out_index  = out_valid ? mem_idx[rd_ptr]  : '0;

    // Shift register and index stay stable in IDLE, so the push edge still sees the finished word.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_data[wr_ptr] <= shreg;
            mem_idx[wr_ptr]  <= idx_reg;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            frame_done <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            if (push_ok)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)
                rd_ptr <= rd_ptr + PTR_W'(1);
            if (push_ok && !pop)
                count <= count + CNT_W'(1);
            else if (!push_ok && pop)
                count <= count - CNT_W'(1);
            frame_done <= push_ok && (idx_reg == LAST_IDX);
            overrun    <= (overrun && !clr_err) || (push_req && !push_ok);
        end
    end

`ifdef SPECTRO_RX_SEQ_CHECK_EN
    logic [IDX_W-1:0] exp_idx;
    logic             word_done;

    assign word_done = (state == SHIFT) && !sl_in && (bitcnt == LAST_BIT);

    // After a mismatch the expectation resyncs to the received index so one glitch flags only once.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            exp_idx <= '0;
            seq_err <= 1'b0;
        end else begin
            if (word_done)
                exp_idx <= (idx_reg == LAST_IDX) ? '0 : idx_reg + IDX_W'(1);
            seq_err <= (seq_err && !clr_err) || (word_done && (idx_reg != exp_idx));
        end
    end
`else
    assign seq_err = 1'b0;
`endif

endmodule

// File: doc/spectrogram_frame_receiver.md
Name: spectrogram_frame_receiver

Overview:
- Receive-side counterpart of the spectrogram extractor's serial readout.
- Deserialises the PISO bitstream framed by the SL strobe into 12-bit words: the RTC word (index 0) followed by channel counters 1..15.
- Each word is tagged with the 4-bit selection index and buffered in a small FIFO.
- Words are presented on a valid/ready stream for the host-side capture logic.

Parameters:
- WORD_W, 12, bits per serial word (counter width).
- IDX_W, 4, width of word index / selection bits.
- NUM_WORDS, 16, words per frame (index 0 = RTC, 1..15 = channels).
- FIFO_DEPTH, 4, output FIFO entries (power of two, >= 2).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-low reset.
- serial_in  in  1  serial data from the extractor's serial_out, MSB first.
- sl_in  in  1  shift/load strobe from the extractor; 1 = load cycle (word boundary), 0 = shift.
- sel_in  in  IDX_W  word index (a3..a0) from the extractor, valid during the load cycle.
- clr_err  in  1  synchronous clear of sticky error flags.
- out_data  out  WORD_W  FIFO head word.
- out_index  out  IDX_W  index of FIFO head word.
- out_valid  out  1  FIFO non-empty.
- out_ready  in  1  consumer accepts head when out_valid & out_ready.
- frame_done  out  1  one-cycle pulse when a word with index NUM_WORDS-1 is pushed.
- err_short  out  1  one-cycle pulse when a word is truncated by an early load.
- overrun  out  1  sticky: a completed word was dropped because the FIFO was full.
- seq_err  out  1  sticky: index sequence violation (optional feature only).
- fifo_count  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (reset=0, async): FSM=IDLE, bit counter=0, shift reg=0, FIFO empty, out_valid=0, out_data=0, out_index=0, frame_done=0, err_short=0, overrun=0, seq_err=0, fifo_count=0, expected index=0.
- FSM, IDLE:
  - sl_in=1: capture sel_in into idx_reg, clear bit counter, go to SHIFT.
  - Otherwise stay in IDLE and ignore serial_in.
- FSM, SHIFT (sl_in=0):
  - Each cycle: shreg <= {shreg[WORD_W-2:0], serial_in}; bitcnt++.
  - On the WORD_W-th bit: raise a push request, go to IDLE.
- FSM, SHIFT with sl_in=1 before WORD_W bits:
  - Discard the partial word and pulse err_short.
  - Treat the cycle as a new load: capture sel_in, bitcnt=0, stay in SHIFT.
- Word boundary: sl_in=1 in the same cycle as the WORD_W-th bit is not possible because that cycle has sl_in=0. sl_in=1 on the cycle immediately after is a normal load.
- Latency: the word is pushed on the clock edge after the last bit is sampled and is visible at out_valid on the following cycle when the FIFO was empty.
- Push accepted: if not full, or if full and a pop occurs the same cycle.
- Push rejected: word dropped, overrun <= 1 (sticky).
- Pop: occurs when out_valid & out_ready. Pointers wrap modulo FIFO_DEPTH.
- Simultaneous push and pop: fifo_count unchanged. On an empty FIFO only the push takes effect.
- frame_done pulses in the push cycle (accepted push only) when the pushed index = NUM_WORDS-1.
- clr_err=1: clears overrun and seq_err next edge; a new error in the same cycle wins (flag stays 1).
- Reset mid-word: all state cleared and the partial word is lost. Reception resumes at the next sl_in=1.

Optional Feature:
- Macro: SPECTRO_RX_SEQ_CHECK_EN.
- Defined:
  - Expected-index register (starts at 0) is compared with idx_reg on each completed word.
  - Mismatch sets seq_err (sticky).
  - Expected index is then set to idx_reg+1 (resync), wrapping NUM_WORDS-1 -> 0.
  - The word is pushed regardless.
- Undefined: no expected-index logic; seq_err tied to 0.

Test Plan:
- Reset release, sl_in=1 with sel_in=0, then 12 bits of 0xA5C MSB first -> one cycle later out_valid=1, out_data=0xA5C, out_index=0, fifo_count=1.
- Full frame of 16 words, indices 0..15, data 0x100+i, out_ready=1 -> 16 words delivered in order, frame_done pulses exactly once (at index 15), no error flags.
- Load, 5 bits, then sl_in=1 with sel_in=3 and 12 bits of 0xFFF -> err_short pulses once, only (0xFFF, 3) is delivered.
- out_ready=0, 5 words sent with FIFO_DEPTH=4 -> fifo_count=4, overrun=1, first 4 words retained. After clr_err, overrun=0.
- With SPECTRO_RX_SEQ_CHECK_EN: indices 0,1,3,4 -> seq_err=1 after the word with index 3, no further error at index 4. Without the macro, seq_err stays 0.
- Assert reset (0) during bit 7 of a word -> outputs return to reset values immediately; the next full word is received correctly.
